quadrature_decoder: RTL and testbench

QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

---
 rtl/uniboard_pkg.sv | 47 ++++
 rtl/quadrature_decoder_input_filter.sv | 58 +++++
 rtl/quadrature_decoder.sv | 171 +++++++++++++++++
 tb/tb_quadrature_decoder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uniboard_pkg.sv
// Shared types and defaults for the encoder front end: step classification,
// decoder state encoding and the quadrature phase helper.
package uniboard_pkg;

  localparam int unsigned DEFAULT_FILTER_LEN = 4;
  localparam int unsigned DEFAULT_VEL_PERIOD = 20000;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ERR
  } step_t;

  typedef enum logic {
    DEC_UNPRIMED,
    DEC_TRACKING
  } dec_state_t;

  // Position of an {A,B} pair along the forward cycle 00->10->11->01.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    logic [1:0] ph;
    case (ab)
      2'b00:   ph = 2'd0;
      2'b10:   ph = 2'd1;
      2'b11:   ph = 2'd2;
      default: ph = 2'd3;
    endcase
    return ph;
  endfunction

  // Phase distance of 2 means both channels moved at once: no usable direction.
  function automatic step_t decode_step(input logic [1:0] prev_ab,
                                        input logic [1:0] cur_ab);
    logic [1:0] delta;
    step_t      st;
    delta = quad_phase(cur_ab) - quad_phase(prev_ab);
    case (delta)
      2'd0:    st = STEP_NONE;
      2'd1:    st = STEP_FWD;
      2'd3:    st = STEP_REV;
      default: st = STEP_ERR;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/quadrature_decoder_input_filter.sv
// Two-flop synchronizer followed by a stability filter for one encoder line.
// valid rises once the post-reset pipeline has had time to settle.
module input_filter
  import uniboard_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt,
  output logic valid
);

  localparam logic [7:0] STABLE_LAST = 8'(FILTER_LEN - 1);
  localparam logic [8:0] WARM_LAST   = 9'(FILTER_LEN + 1);

  logic       sync1;
  logic       sync2;
  logic [7:0] stable_cnt;
  logic [8:0] warm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      filt       <= 1'b0;
      stable_cnt <= '0;
      warm_cnt   <= '0;
      valid      <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;

      if (sync2 != filt) begin
        if (stable_cnt == STABLE_LAST) begin
          filt       <= sync2;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 8'd1;
        end
      end else begin
        stable_cnt <= '0;
      end

      // Timed so valid rises on the same edge a level held through reset
      // release reaches filt, letting the decoder seed from it.
      if (!valid) begin
        if (warm_cnt == WARM_LAST) begin
          valid <= 1'b1;
        end else begin
          warm_cnt <= warm_cnt + 9'd1;
        end
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: filtered A/B/index inputs, signed position count,
// index capture, sticky illegal-transition flag and windowed velocity.
module quadrature_decoder
  import uniboard_pkg::*;
#(
  parameter int unsigned COUNT_W    = 32,
  parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN,
  parameter int unsigned VEL_PERIOD = DEFAULT_VEL_PERIOD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enc_a,
  input  logic                      enc_b,
  input  logic                      enc_i,
  input  logic                      clear,
  input  logic                      err_clear,
  output logic signed [COUNT_W-1:0] count,
  output logic                      dir,
  output logic signed [COUNT_W-1:0] index_count,
  output logic                      index_pulse,
  output logic signed [15:0]        velocity,
  output logic                      vel_valid,
  output logic                      err
);

  localparam int unsigned              WIN_W     = $clog2(VEL_PERIOD);
  localparam logic [WIN_W-1:0]         WIN_LAST  = WIN_W'(VEL_PERIOD - 1);
  localparam logic [WIN_W-1:0]         WIN_ONE   = WIN_W'(1);
  localparam logic signed [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  logic filt_a, filt_b, filt_i;
  logic valid_a, valid_b, valid_i;
  logic primed;

  input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .raw   (enc_a),
    .filt  (filt_a),
    .valid (valid_a)
  );

  input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .raw   (enc_b),
    .filt  (filt_b),
    .valid (valid_b)
  );

  input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_i (
    .clk   (clk),
    .reset (reset),
    .raw   (enc_i),
    .filt  (filt_i),
    .valid (valid_i)
  );

  assign primed = valid_a & valid_b & valid_i;

  dec_state_t state;
  logic [1:0] prev_ab;
  logic       prev_i;
  logic [1:0] cur_ab;
  step_t      step;

  assign cur_ab = {filt_a, filt_b};

  always_comb begin
    step = STEP_NONE;
    if (state == DEC_TRACKING) begin
      step = decode_step(prev_ab, cur_ab);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= DEC_UNPRIMED;
      prev_ab     <= '0;
      prev_i      <= 1'b0;
      count       <= '0;
      dir         <= 1'b0;
      index_count <= '0;
      index_pulse <= 1'b0;
      err         <= 1'b0;
    end else begin
      index_pulse <= 1'b0;
      prev_ab     <= cur_ab;
      prev_i      <= filt_i;

      case (state)
        DEC_UNPRIMED: begin
          if (primed) begin
            state <= DEC_TRACKING;
          end
        end
        DEC_TRACKING: begin
          if (filt_i && !prev_i) begin
            index_count <= count;
            index_pulse <= 1'b1;
          end
        end
        default: state <= DEC_UNPRIMED;
      endcase

      if (clear) begin
        count <= '0;
      end else if (step == STEP_FWD) begin
        count <= count + COUNT_ONE;
      end else if (step == STEP_REV) begin
        count <= count - COUNT_ONE;
      end

      if (step == STEP_FWD) begin
        dir <= 1'b1;
      end else if (step == STEP_REV) begin
        dir <= 1'b0;
      end

      if (step == STEP_ERR) begin
        err <= 1'b1;
      end else if (err_clear) begin
        err <= 1'b0;
      end
    end
  end

  logic [WIN_W-1:0]   win_cnt;
  logic signed [15:0] vel_acc;
  logic signed [16:0] vel_sum;
  logic signed [15:0] vel_next;

  always_comb begin
    vel_sum = {vel_acc[15], vel_acc};
    case (step)
      STEP_FWD: vel_sum = vel_sum + 17'sd1;
      STEP_REV: vel_sum = vel_sum - 17'sd1;
      default:  vel_sum = vel_sum;
    endcase
    if (vel_sum > 17'sd32767) begin
      vel_next = 16'sh7FFF;
    end else if (vel_sum < -17'sd32768) begin
      vel_next = 16'sh8000;
    end else begin
      vel_next = vel_sum[15:0];
    end
  end

  // The step landing on the last window cycle goes into the published
  // velocity, not into the restarted accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt   <= '0;
      vel_acc   <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      if (win_cnt == WIN_LAST) begin
        win_cnt   <= '0;
        vel_acc   <= '0;
        velocity  <= vel_next;
        vel_valid <= 1'b1;
      end else begin
        win_cnt   <= win_cnt + WIN_ONE;
        vel_acc   <= vel_next;
        vel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Randomized scoreboard bench for quadrature_decoder (COUNT_W=8, FILTER_LEN=4,
// VEL_PERIOD=100) against a phase/step-level reference model.
module tb_quadrature_decoder;

  localparam int CW  = 8;
  localparam int FL  = 4;
  localparam int VP  = 100;
  localparam int LAT = FL + 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enc_a = 1'b0, enc_b = 1'b0, enc_i = 1'b0;
  logic clear = 1'b0, err_clear = 1'b0;
  logic signed [CW-1:0] count;
  logic signed [CW-1:0] index_count;
  logic                 dir, index_pulse, vel_valid, err;
  logic signed [15:0]   velocity;

  quadrature_decoder #(
    .COUNT_W    (CW),
    .FILTER_LEN (FL),
    .VEL_PERIOD (VP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .enc_i       (enc_i),
    .clear       (clear),
    .err_clear   (err_clear),
    .count       (count),
    .dir         (dir),
    .index_count (index_count),
    .index_pulse (index_pulse),
    .velocity    (velocity),
    .vel_valid   (vel_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   due;
    logic signed [CW-1:0] cnt;
    logic                 d;
  } cnt_exp_t;

  typedef struct {
    int due;
    int val;
  } val_exp_t;

  cnt_exp_t cnt_q[$];
  val_exp_t idx_q[$];
  val_exp_t err_q[$];
  int       delta_at[int];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  int                   pos = 0;
  logic signed [CW-1:0] m_count = '0;
  logic                 m_dir = 1'b0;
  logic signed [CW-1:0] last_count = '0;

  always @(posedge clk) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [1:0] ab_of(input int p);
    case (p)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cnt_exp_t e;
    val_exp_t v;
    int       s;
    bit       exp_v;
    if (mon_en) begin
      if (reset) begin
        last_count = '0;
      end else begin
        if (count !== last_count) begin
          if (cnt_q.size() == 0) begin
            check("count_unexpected", int'(count), int'(last_count));
          end else begin
            e = cnt_q.pop_front();
            check("count_value", int'(count), int'(e.cnt));
            check("count_dir", int'(dir), int'(e.d));
            check("count_cycle", cyc, e.due);
          end
        end else if (cnt_q.size() > 0 && cnt_q[0].due < cyc) begin
          e = cnt_q.pop_front();
          check("count_timeout", cyc, e.due);
        end
        last_count = count;

        if (index_pulse) begin
          if (idx_q.size() == 0) begin
            check("index_unexpected", int'(index_pulse), 0);
          end else begin
            v = idx_q.pop_front();
            check("index_count", int'(index_count), v.val);
            check("index_cycle", cyc, v.due);
          end
        end else if (idx_q.size() > 0 && idx_q[0].due < cyc) begin
          v = idx_q.pop_front();
          check("index_timeout", cyc, v.due);
        end

        while (err_q.size() > 0 && err_q[0].due <= cyc) begin
          v = err_q.pop_front();
          check("err", int'(err), v.val);
        end

        exp_v = (cyc > 0) && (cyc % VP == 0);
        if (vel_valid || exp_v) begin
          check("vel_valid", int'(vel_valid), int'(exp_v));
          if (vel_valid && exp_v) begin
            s = 0;
            for (int t = cyc - VP + 1; t <= cyc; t++) begin
              if (delta_at.exists(t)) s += delta_at[t];
            end
            check("velocity", int'(velocity), s);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_step(input int d, input bit with_clear);
    pos = (pos + d + 4) % 4;
    {enc_a, enc_b} = ab_of(pos);
    m_count = m_count + CW'(d);
    m_dir = (d > 0);
    if (with_clear) m_count = '0;
    cnt_q.push_back('{due: cyc + LAT, cnt: m_count, d: m_dir});
    delta_at[cyc + LAT] = d;
  endtask

  task automatic double_toggle();
    pos = (pos + 2) % 4;
    {enc_a, enc_b} = ab_of(pos);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    if (m_count != 0) cnt_q.push_back('{due: cyc + 1, cnt: '0, d: m_dir});
    m_count = '0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    err_q.push_back('{due: cyc + 1, val: 0});
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  task automatic glitch(input int ch, input int len);
    case (ch)
      0:       enc_a = ~enc_a;
      1:       enc_b = ~enc_b;
      default: enc_i = ~enc_i;
    endcase
    idle(len);
    case (ch)
      0:       enc_a = ~enc_a;
      1:       enc_b = ~enc_b;
      default: enc_i = ~enc_i;
    endcase
  endtask

  task automatic apply_reset(input int hold);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    mon_en = 1'b1;
    check("reset_count", int'(count), 0);
    check("reset_index_count", int'(index_count), 0);
    check("reset_velocity", int'(velocity), 0);
    check("reset_flags", int'({dir, index_pulse, vel_valid, err}), 0);
    check("reset_pending", cnt_q.size() + idx_q.size() + err_q.size(), 0);
    m_count = '0;
    m_dir = 1'b0;
    delta_at.delete();
    idle(hold);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    apply_reset(3);
    idle(12);

    // eight forward edges, 20 cycles apart
    for (int i = 0; i < 8; i++) begin
      do_step(1, 1'b0);
      idle(20);
    end

    // sub-threshold pulse on A
    glitch(0, 3);
    err_q.push_back('{due: cyc + 15, val: 0});
    idle(20);

    for (int i = 0; i < 4; i++) begin
      do_step(-1, 1'b0);
      idle(20);
    end

    // index rising at count = 5
    do_step(1, 1'b0);
    idle(20);
    enc_i = 1'b1;
    idx_q.push_back('{due: cyc + LAT, val: int'(m_count)});
    idle(20);
    enc_i = 1'b0;
    idle(12);

    // ten forward steps inside one velocity window
    while (cyc % VP != 5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      do_step(1, 1'b0);
      idle(8);
    end
    idle(20);

    // illegal double transition, sticky err, err_clear
    double_toggle();
    err_q.push_back('{due: cyc + LAT, val: 1});
    err_q.push_back('{due: cyc + LAT + 6, val: 1});
    idle(15);
    pulse_err_clear();
    idle(10);
    double_toggle();
    err_q.push_back('{due: cyc + LAT, val: 1});
    idle(LAT - 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    idle(10);
    pulse_err_clear();
    idle(10);

    // randomized steps, glitches and clears
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 9));
      if (k < 6) begin
        do_step(($urandom_range(0, 1) == 1) ? 1 : -1, 1'b0);
        idle(int'($urandom_range(8, 15)));
      end else if (k < 9) begin
        glitch(int'($urandom_range(0, 2)), int'($urandom_range(1, FL - 1)));
        idle(8);
      end else begin
        pulse_clear();
        idle(4);
      end
    end
    err_q.push_back('{due: cyc + 10, val: 0});
    idle(15);

    // wrap at both extremes of an 8-bit count
    if (m_count != 0) pulse_clear();
    idle(4);
    for (int i = 0; i < 128; i++) begin
      do_step(1, 1'b0);
      idle(6);
    end
    do_step(-1, 1'b0);
    idle(6);
    do_step(1, 1'b0);
    idle(12);

    // step, index rise and clear landing on the same decode cycle
    idx_q.push_back('{due: cyc + LAT, val: int'(m_count)});
    enc_i = 1'b1;
    do_step(1, 1'b1);
    idle(LAT - 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idle(15);
    enc_i = 1'b0;
    idle(15);

    // reset mid-window with an illegal edge still in the filter; lines held at 11
    while (cyc % VP != 50) @(negedge clk);
    pos = 2;
    {enc_a, enc_b} = ab_of(pos);
    enc_i = 1'b1;
    idle(2);
    apply_reset(3);
    err_q.push_back('{due: cyc + 30, val: 0});
    idle(40);
    enc_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_step(1, 1'b0);
      idle(10);
    end
    while (cyc < VP + 10) @(negedge clk);
    idle(30);

    check("cnt_q_drained", cnt_q.size(), 0);
    check("idx_q_drained", idx_q.size(), 0);
    check("err_q_drained", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
